// File: rtl/soc_system_mult_engine_if.sv
// Bundle of the engine's control handshake (start/busy/done) and the s2 port
// of the 4-word dual-port on-chip RAM. The engine uses the master modport;
// whatever drives start and returns readdata2 (RAM side / host) uses slave.
interface soc_system_mult_engine_if;
    logic        start;
    logic        busy;
    logic        done;
    logic [1:0]  address2;
    logic        chipselect2;
    logic        write2;
    logic [3:0]  byteenable2;
    logic [31:0] writedata2;
    logic [31:0] readdata2;
    logic        clken2;

    modport master (
        input  start,
        input  readdata2,
        output busy,
        output done,
        output address2,
        output chipselect2,
        output write2,
        output byteenable2,
        output writedata2,
        output clken2
    );

    modport slave (
        output start,
        output readdata2,
        input  busy,
        input  done,
        input  address2,
        input  chipselect2,
        input  write2,
        input  byteenable2,
        input  writedata2,
        input  clken2
    );
endinterface

// File: rtl/soc_system_mult_engine.sv
// Sequential 32x32->64 shift-add multiplier mastering RAM port s2.
// Reads A (ADDR_A) and B (ADDR_B), iterates 32 cycles, writes the product
// low word to ADDR_LO and high word to ADDR_HI, then pulses done.
// Optional feature macro: MULT_ENGINE_SIGNED_EN (two's-complement operands;
// magnitudes are multiplied and the product negated on write if signs differ).
// All bus outputs are registered; they are computed from the next state so
// they line up with the state they belong to.
module soc_system_mult_engine #(
    parameter logic [1:0] ADDR_A  = 2'd0,
    parameter logic [1:0] ADDR_B  = 2'd1,
    parameter logic [1:0] ADDR_LO = 2'd2,
    parameter logic [1:0] ADDR_HI = 2'd3
) (
    input  logic                      clk,
    input  logic                      reset,
    soc_system_mult_engine_if.master  bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_A,
        S_RD_B,
        S_CAP_B,
        S_MUL,
        S_WR_LO,
        S_WR_HI,
        S_DONE
    } state_t;

    state_t      state_q, state_d;
    // B is never held on its own: it is loaded straight into the low half of P.
    logic [31:0] a_q, a_d;
    logic [63:0] p_q, p_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [32:0] mul_sum;
    logic [31:0] b_load;
    logic [63:0] result;

    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [1:0]  address2_q, address2_d;
    logic        chipselect2_q, chipselect2_d;
    logic        write2_q, write2_d;
    logic [31:0] writedata2_q, writedata2_d;

`ifdef MULT_ENGINE_SIGNED_EN
    logic        sign_q, sign_d;

    // Two's-complement magnitude; 0x80000000 maps to itself, which is the
    // correct unsigned magnitude.
    function automatic logic [31:0] mag32(input logic [31:0] v);
        return v[31] ? (~v + 32'd1) : v;
    endfunction
`endif

    // One shift-add step: add A to the upper half when the LSB of P is set.
    assign mul_sum = {1'b0, p_q[63:32]} + (p_q[0] ? {1'b0, a_q} : 33'd0);

`ifdef MULT_ENGINE_SIGNED_EN
    assign b_load = mag32(bus.readdata2);
`else
    assign b_load = bus.readdata2;
`endif

    // Next-state and datapath update.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        p_d     = p_q;
        cnt_d   = cnt_q;
`ifdef MULT_ENGINE_SIGNED_EN
        sign_d  = sign_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d = S_RD_A;
                end
            end
            S_RD_A: begin
                state_d = S_RD_B;
            end
            S_RD_B: begin
                // Data for ADDR_A arrives one cycle after its address.
                a_d     = bus.readdata2;
                state_d = S_CAP_B;
            end
            S_CAP_B: begin
`ifdef MULT_ENGINE_SIGNED_EN
                a_d     = mag32(a_q);
                sign_d  = a_q[31] ^ bus.readdata2[31];
`endif
                p_d     = {32'h0, b_load};
                cnt_d   = 5'd0;
                state_d = S_MUL;
            end
            S_MUL: begin
                p_d   = {mul_sum, p_q[31:1]};
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd31) begin
                    state_d = S_WR_LO;
                end
            end
            S_WR_LO: begin
                state_d = S_WR_HI;
            end
            S_WR_HI: begin
                state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Registered bus outputs, derived from the state being entered.
    always_comb begin
`ifdef MULT_ENGINE_SIGNED_EN
        result = sign_d ? (~p_d + 64'd1) : p_d;
`else
        result = p_d;
`endif
        busy_d        = 1'b0;
        done_d        = 1'b0;
        address2_d    = 2'd0;
        chipselect2_d = 1'b0;
        write2_d      = 1'b0;
        writedata2_d  = 32'h0;
        case (state_d)
            S_RD_A: begin
                busy_d        = 1'b1;
                address2_d    = ADDR_A;
                chipselect2_d = 1'b1;
            end
            S_RD_B: begin
                busy_d        = 1'b1;
                address2_d    = ADDR_B;
                chipselect2_d = 1'b1;
            end
            S_CAP_B, S_MUL: begin
                busy_d = 1'b1;
            end
            S_WR_LO: begin
                busy_d        = 1'b1;
                address2_d    = ADDR_LO;
                chipselect2_d = 1'b1;
                write2_d      = 1'b1;
                writedata2_d  = result[31:0];
            end
            S_WR_HI: begin
                busy_d        = 1'b1;
                address2_d    = ADDR_HI;
                chipselect2_d = 1'b1;
                write2_d      = 1'b1;
                writedata2_d  = result[63:32];
            end
            S_DONE: begin
                done_d = 1'b1;
            end
            default: begin
                busy_d = 1'b0;
            end
        endcase
    end

    // State, datapath and output registers; reset aborts any access at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= S_IDLE;
            a_q           <= 32'h0;
            p_q           <= 64'h0;
            cnt_q         <= 5'd0;
`ifdef MULT_ENGINE_SIGNED_EN
            sign_q        <= 1'b0;
`endif
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            address2_q    <= 2'd0;
            chipselect2_q <= 1'b0;
            write2_q      <= 1'b0;
            writedata2_q  <= 32'h0;
        end else begin
            state_q       <= state_d;
            a_q           <= a_d;
            p_q           <= p_d;
            cnt_q         <= cnt_d;
`ifdef MULT_ENGINE_SIGNED_EN
            sign_q        <= sign_d;
`endif
            busy_q        <= busy_d;
            done_q        <= done_d;
            address2_q    <= address2_d;
            chipselect2_q <= chipselect2_d;
            write2_q      <= write2_d;
            writedata2_q  <= writedata2_d;
        end
    end

    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.address2    = address2_q;
    assign bus.chipselect2 = chipselect2_q;
    assign bus.write2      = write2_q;
    assign bus.writedata2  = writedata2_q;
    assign bus.byteenable2 = 4'hF;
    assign bus.clken2      = 1'b1;

endmodule

// File: tb/tb_soc_system_mult_engine.sv
// Testbench for soc_system_mult_engine: models the 4-word dual-port RAM
// (s1 for the host, s2 for the engine), issues directed operand pairs, and
// checks every s2 write against a queue of expected (address, data) pairs.
module tb_soc_system_mult_engine;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    soc_system_mult_engine_if bus();

    soc_system_mult_engine dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Host-side s1 port of the RAM model.
    logic [1:0]  s1_addr;
    logic        s1_we;
    logic [31:0] s1_wdata;
    logic [31:0] mem [4];

    // RAM model: registered address, so read data appears one cycle later.
    always @(posedge clk) begin
        if (s1_we) mem[s1_addr] <= s1_wdata;
        if (bus.clken2) begin
            if (bus.chipselect2 && bus.write2) mem[bus.address2] <= bus.writedata2;
            bus.readdata2 <= mem[bus.address2];
        end
    end

    typedef struct packed {
        logic [1:0]  addr;
        logic [31:0] data;
    } wr_t;

    wr_t exp_q[$];
    wr_t mon_e;
    int  checks = 0;
    int  errors = 0;
    logic [31:0] prev_lo, prev_hi;

    // Monitor: every s2 write is popped against the expectation queue.
    always @(negedge clk) begin
        if (!reset && bus.chipselect2 && bus.write2) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL s2_write_unexpected: got addr=%0d data=%h, required no write",
                         bus.address2, bus.writedata2);
            end else begin
                mon_e = exp_q.pop_front();
                if (bus.address2 !== mon_e.addr || bus.writedata2 !== mon_e.data) begin
                    errors++;
                    $display("FAIL s2_write: got addr=%0d data=%h, required addr=%0d data=%h",
                             bus.address2, bus.writedata2, mon_e.addr, mon_e.data);
                end else begin
                    $display("s2 write addr=%0d data=%h ok", bus.address2, bus.writedata2);
                end
            end
        end
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, got, exp);
        end
    endtask

    task automatic hps_write(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        s1_addr  = a;
        s1_wdata = d;
        s1_we    = 1'b1;
        @(negedge clk);
        s1_we    = 1'b0;
    endtask

    task automatic expect_product(input logic [31:0] lo, input logic [31:0] hi);
        exp_q.push_back(wr_t'{addr: 2'd2, data: lo});
        exp_q.push_back(wr_t'{addr: 2'd3, data: hi});
    endtask

    // Counts done pulses over a window in which no run should complete.
    task automatic quiet_window(input string name, input int cycles);
        int dones;
        dones = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (bus.done) dones++;
        end
        check(name, dones, 0);
    endtask

    // One run; optionally pulses start for one cycle at cycle pulse_at (MUL).
    task automatic run_vec(input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] lo, input logic [31:0] hi,
                           input int pulse_at);
        int n;
        bit seen;
        hps_write(2'd0, a);
        hps_write(2'd1, b);
        expect_product(lo, hi);
        @(negedge clk);
        bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        n = 0;
        seen = 1'b0;
        while (n < 100 && !seen) begin
            @(negedge clk);
            n++;
            bus.start = (n == pulse_at);
            if (n == 1) check("busy_cycle1", bus.busy, 1);
            if (n == 37) check("busy_cycle37", bus.busy, 1);
            if (bus.done) seen = 1'b1;
        end
        bus.start = 1'b0;
        check("done_latency", n, 38);
        check("busy_in_done", bus.busy, 0);
        $display("run A=%h B=%h expect lo=%h hi=%h latency=%0d", a, b, lo, hi, n);
        quiet_window("no_extra_done", 45);
        prev_lo = lo;
        prev_hi = hi;
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        int first_done;
        int second_done;

        reset     = 1'b1;
        bus.start = 1'b0;
        s1_we     = 1'b0;
        s1_addr   = 2'd0;
        s1_wdata  = 32'h0;
        #1;
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_address2", bus.address2, 0);
        check("rst_chipselect2", bus.chipselect2, 0);
        check("rst_write2", bus.write2, 0);
        check("rst_writedata2", bus.writedata2, 0);
        check("rst_byteenable2", bus.byteenable2, 4'hF);
        check("rst_clken2", bus.clken2, 1);
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // Directed vectors common to both builds.
        run_vec(32'h00000003, 32'h00000005, 32'h0000000F, 32'h00000000, 0);
        run_vec(32'h00000000, 32'h12345678, 32'h00000000, 32'h00000000, 0);
        run_vec(32'h12345678, 32'h00000001, 32'h12345678, 32'h00000000, 0);
        run_vec(32'h00010000, 32'h00010000, 32'h00000000, 32'h00000001, 0);
        run_vec(32'h12345678, 32'h00000010, 32'h23456780, 32'h00000001, 0);
        run_vec(32'h7FFFFFFF, 32'h7FFFFFFF, 32'h00000001, 32'h3FFFFFFF, 0);
        run_vec(32'h80000000, 32'h80000000, 32'h00000000, 32'h40000000, 0);
`ifdef MULT_ENGINE_SIGNED_EN
        run_vec(32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 0);
        run_vec(32'h80000000, 32'h00000002, 32'h00000000, 32'hFFFFFFFF, 0);
        run_vec(32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFE, 32'hFFFFFFFF, 0);
        run_vec(32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFA, 32'hFFFFFFFF, 0);
        run_vec(32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFEB, 32'hFFFFFFFF, 0);
`else
        run_vec(32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFE, 0);
        run_vec(32'h80000000, 32'h00000002, 32'h00000000, 32'h00000001, 0);
        run_vec(32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFE, 32'h00000001, 0);
        run_vec(32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFA, 32'h00000002, 0);
        run_vec(32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFEB, 32'h00000006, 0);
`endif

        // start pulsed during MUL is ignored: exactly one done.
        run_vec(32'h00000009, 32'h0000000B, 32'h00000063, 32'h00000000, 20);

        // start held high: back-to-back runs every 39 cycles.
        hps_write(2'd0, 32'h00000006);
        hps_write(2'd1, 32'h00000007);
        expect_product(32'h0000002A, 32'h00000000);
        expect_product(32'h0000002A, 32'h00000000);
        @(negedge clk);
        bus.start = 1'b1;
        n = 0;
        first_done = -1;
        second_done = -1;
        while (n < 200 && second_done < 0) begin
            @(negedge clk);
            n++;
            if (bus.done) begin
                if (first_done < 0) first_done = n;
                else second_done = n;
            end
        end
        bus.start = 1'b0;
        check("held_first_done", first_done, 38);
        check("held_done_period", second_done - first_done, 39);
        $display("held start: done at cycles %0d and %0d", first_done, second_done);
        quiet_window("held_no_third_run", 45);
        prev_lo = 32'h0000002A;
        prev_hi = 32'h00000000;

        // Reset in the middle of MUL: outputs drop at once, no write happens.
        hps_write(2'd0, 32'hABCDEF01);
        hps_write(2'd1, 32'h00000055);
        @(negedge clk);
        bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        for (int i = 0; i < 20; i++) @(negedge clk);
        check("mul_busy_before_reset", bus.busy, 1);
        reset = 1'b1;
        #1;
        check("reset_busy_drop", bus.busy, 0);
        check("reset_chipselect2", bus.chipselect2, 0);
        check("reset_write2", bus.write2, 0);
        check("reset_done", bus.done, 0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        quiet_window("reset_no_done", 45);
        check("reset_word2_kept", mem[2], prev_lo);
        check("reset_word3_kept", mem[3], prev_hi);
        $display("reset abort: word2=%h word3=%h", mem[2], mem[3]);

        // Normal run after reset.
        run_vec(32'h00000003, 32'h00000005, 32'h0000000F, 32'h00000000, 0);
        check("post_word2", mem[2], 32'h0000000F);
        check("post_word3", mem[3], 32'h00000000);

        check("queue_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
